// File: rtl/cellrv32_cpu_wb_queue_pkg.sv
// Shared types and constants for the long-latency write-back queue.
package cellrv32_package;

    localparam int unsigned wb_xlen_c        = 32;
    localparam int unsigned wb_queue_depth_c = 4;
    localparam int unsigned reg_addr_w_c     = 5;

    typedef struct packed {
        logic [reg_addr_w_c-1:0] rd;
        logic [wb_xlen_c-1:0]    data;
    } wb_req_t;

    // Embedded (16-register) cores only decode rd[3:0]
    function automatic logic [reg_addr_w_c-1:0] rd_mask(input logic [reg_addr_w_c-1:0] rd,
                                                         input bit e_mode);
        return e_mode ? {1'b0, rd[3:0]} : rd;
    endfunction

endpackage

// File: rtl/cellrv32_cpu_wb_queue_if.sv
// Result sources, write-back head and hazard lookup of the write-back queue.
interface cellrv32_cpu_wb_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush_i;
    logic            alloc_i;
    logic [4:0]      alloc_rd_i;
    logic [4:0]      chk_rs1_i;
    logic [4:0]      chk_rs2_i;
    logic [4:0]      chk_rs3_i;
    logic [4:0]      chk_rd_i;
    logic            hazard_o;
    logic            mem_valid_i;
    logic [4:0]      mem_rd_i;
    logic [XLEN-1:0] mem_data_i;
    logic            mem_ready_o;
    logic            cp_valid_i;
    logic [4:0]      cp_rd_i;
    logic [XLEN-1:0] cp_data_i;
    logic            cp_ready_o;
    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            wb_ack_i;
    logic            empty_o;
    logic            full_o;

    modport master (
        output flush_i, alloc_i, alloc_rd_i, chk_rs1_i, chk_rs2_i, chk_rs3_i, chk_rd_i,
        output mem_valid_i, mem_rd_i, mem_data_i, cp_valid_i, cp_rd_i, cp_data_i, wb_ack_i,
        input  hazard_o, mem_ready_o, cp_ready_o, wb_valid_o, wb_rd_o, wb_data_o,
        input  empty_o, full_o
    );

    modport slave (
        input  flush_i, alloc_i, alloc_rd_i, chk_rs1_i, chk_rs2_i, chk_rs3_i, chk_rd_i,
        input  mem_valid_i, mem_rd_i, mem_data_i, cp_valid_i, cp_rd_i, cp_data_i, wb_ack_i,
        output hazard_o, mem_ready_o, cp_ready_o, wb_valid_o, wb_rd_o, wb_data_o,
        output empty_o, full_o
    );

endinterface

// File: rtl/cellrv32_cpu_wb_queue_scoreboard.sv
// Pending-result scoreboard: one bit per GPR, set on issue, cleared on write-back.
module cellrv32_cpu_wb_scoreboard
    import cellrv32_package::*;
#(
    parameter bit E_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    set_en,
    input  logic [reg_addr_w_c-1:0] set_rd,
    input  logic                    clr_en,
    input  logic [reg_addr_w_c-1:0] clr_rd,
    input  logic [reg_addr_w_c-1:0] rs1,
    input  logic [reg_addr_w_c-1:0] rs2,
    input  logic [reg_addr_w_c-1:0] rs3,
    input  logic [reg_addr_w_c-1:0] rd,
    output logic                    hazard_c
);

    // x0 never pends; upper half does not exist on embedded cores
    localparam logic [31:0] REG_MASK = E_MODE ? 32'h0000_fffe : 32'hffff_fffe;

    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    // Set is applied after clear so a same-cycle re-issue keeps the bit
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[rd_mask(set_rd, E_MODE)] = 1'b1;
        if (clr_en) clr_vec[rd_mask(clr_rd, E_MODE)] = 1'b1;
        pending_nxt = ((pending & ~clr_vec) | set_vec) & REG_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign hazard_c = pending[rd_mask(rs1, E_MODE)] | pending[rd_mask(rs2, E_MODE)] |
                      pending[rd_mask(rs3, E_MODE)] | pending[rd_mask(rd, E_MODE)];

endmodule

// File: rtl/cellrv32_cpu_wb_queue.sv
// Write-back queue: dual-push FIFO (mem ahead of co-processor) feeding the register file port.
module cellrv32_cpu_wb_queue
    import cellrv32_package::*;
#(
    parameter int unsigned XLEN                  = 32,
    parameter int unsigned CPU_EXTENSION_RISCV_E = 0,
    parameter int unsigned FIFO_DEPTH            = wb_queue_depth_c
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    cellrv32_cpu_wb_queue_if.slave bus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam bit          E_MODE = (CPU_EXTENSION_RISCV_E != 0);

    wb_req_t                 storage [FIFO_DEPTH];
    wb_req_t                 head;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        cp_slot;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        free;
    logic [CNT_W-1:0]        push_cnt;
    logic [reg_addr_w_c-1:0] mem_rd;
    logic [reg_addr_w_c-1:0] cp_rd;
    logic                    mem_ready;
    logic                    cp_ready;
    logic                    mem_store;
    logic                    cp_store;
    logic                    wb_valid;
    logic                    pop;
    logic                    hazard;

    // Slot accounting ignores this cycle's pop so ready never depends on wb_ack
    assign free      = CNT_W'(FIFO_DEPTH) - count;
    assign mem_ready = (free >= CNT_W'(1));
    assign cp_ready  = (free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~bus.mem_valid_i);

    // Results for x0 complete the handshake but never occupy a slot
    assign mem_rd    = rd_mask(bus.mem_rd_i, E_MODE);
    assign cp_rd     = rd_mask(bus.cp_rd_i, E_MODE);
    assign mem_store = bus.mem_valid_i & mem_ready & (mem_rd != '0);
    assign cp_store  = bus.cp_valid_i & cp_ready & (cp_rd != '0);
    assign push_cnt  = CNT_W'(mem_store) + CNT_W'(cp_store);
    assign cp_slot   = wr_ptr + PTR_W'(mem_store);

    assign wb_valid  = (count != '0);
    assign pop       = wb_valid & bus.wb_ack_i;
    assign head      = storage[rd_ptr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                storage[i] <= '0;
            end
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_store) begin
                storage[wr_ptr] <= '{rd: mem_rd, data: wb_xlen_c'(bus.mem_data_i)};
            end
            if (cp_store) begin
                storage[cp_slot] <= '{rd: cp_rd, data: wb_xlen_c'(bus.cp_data_i)};
            end
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + push_cnt - CNT_W'(pop);
        end
    end

    cellrv32_cpu_wb_scoreboard #(
        .E_MODE (E_MODE)
    ) u_scoreboard (
        .clk      (clk_i),
        .rst_n    (rstn_i),
        .flush    (bus.flush_i),
        .set_en   (bus.alloc_i),
        .set_rd   (bus.alloc_rd_i),
        .clr_en   (pop),
        .clr_rd   (head.rd),
        .rs1      (bus.chk_rs1_i),
        .rs2      (bus.chk_rs2_i),
        .rs3      (bus.chk_rs3_i),
        .rd       (bus.chk_rd_i),
        .hazard_c (hazard)
    );

    assign bus.hazard_o    = hazard;
    assign bus.mem_ready_o = mem_ready;
    assign bus.cp_ready_o  = cp_ready;
    assign bus.wb_valid_o  = wb_valid;
    assign bus.wb_rd_o     = head.rd;
    assign bus.wb_data_o   = XLEN'(head.data);
    assign bus.empty_o     = ~wb_valid;
    assign bus.full_o      = (count == CNT_W'(FIFO_DEPTH));

endmodule
